bp_me_stream_arbiter: RTL and testbench
=======================================

// Module: bp_me_stream_arbiter
// PURPOSE
//  Round-robin arbiter that shares one BedRock Stream output among num_req_p Stream requesters.
//  - Sits between several burst-to-stream converters and a single downstream stream consumer.
//  - Grant locks from the first accepted beat of a message through its last beat, so messages never interleave.
//  - Zero-latency mux: the winning requester's beat appears on the output in the same cycle.
// PARAMETERS
//  num_req_p      2    number of requesters (>=2)
//  header_width_p 128  BedRock header width in bits
//  data_width_p   64   stream data beat width
//  cnt_width_p    16   width of per-requester message counters (BP_ME_STREAM_ARB_PERF_EN only)
// PORTS
//  clk_i               in   1                     clock
//  reset_n_i           in   1                     reset; asynchronous assert, active-low
//  in_msg_header_i     in   num_req_p*header_w    per-requester header; slice i = requester i
//  in_msg_data_i       in   num_req_p*data_w      per-requester data beat
//  in_msg_v_i          in   num_req_p             per-requester beat valid
//  in_msg_last_i       in   num_req_p             per-requester last-beat flag
//  in_msg_ready_and_o  out  num_req_p             per-requester ready (ready-valid-and)
//  out_msg_header_o    out  header_width_p        granted header
//  out_msg_data_o      out  data_width_p          granted data
//  out_msg_v_o         out  1                     output valid
//  out_msg_last_o      out  1                     output last
//  out_msg_ready_and_i in   1                     downstream ready
//  grant_o             out  num_req_p             one-hot current grant; 0 when nothing is selected
// BEHAVIOUR
//  State and reset
//  - State: e_ready (no message in flight) or e_busy (grant locked).
//  - Registers: state, lock_id_r, rr_ptr_r.
//  - Reset (reset_n_i=0, async) puts state=e_ready, rr_ptr_r=0, lock_id_r=0.
//  - While reset is asserted, all outputs are driven 0.
//  Grant selection
//  - e_ready: sel = first i with in_msg_v_i[i]=1, searching from rr_ptr_r upward with wrap modulo num_req_p.
//  - e_ready, no valids: grant_o=0, out_msg_v_o=0.
//  - e_busy: sel = lock_id_r, regardless of the other valids.
//  - sel depends only on in_msg_v_i and registers, never on out_msg_ready_and_i (no ready->valid path).
//  Output path
//  - out_* = in_*[sel]; out_msg_v_o = in_msg_v_i[sel] & (state==e_busy | any valid).
//  - in_msg_ready_and_o[i] = out_msg_ready_and_i & grant_o[i]; all other requesters see ready=0.
//  - Output data and header are 0 when grant_o=0.
//  Transitions (on beat accept = out_msg_v_o & out_msg_ready_and_i)
//  - e_ready, accept, ~last: -> e_busy, lock_id_r<=sel.
//  - e_ready, accept, last (single-beat message): stay e_ready, rr_ptr_r<=(sel+1)%num_req_p.
//  - e_busy, accept, last: -> e_ready, rr_ptr_r<=(lock_id_r+1)%num_req_p.
//  - e_busy, granted valid low: hold e_busy with out_msg_v_o=0 (bubble); no re-arbitration.
//  - No accept: registers hold; the e_ready choice may change cycle to cycle until a beat is accepted.
//  Pointer arithmetic
//  - rr_ptr_r is $clog2(num_req_p) bits.
//  - Wrap is explicit compare-to-(num_req_p-1) so non-power-of-2 counts wrap correctly.
//  Latency and ordering
//  - 0-cycle combinational pass-through; no buffering.
//  - Throughput is 1 beat per cycle.
//  Reset mid-message
//  - Returns to e_ready with rr_ptr_r=0; the partial message is abandoned.
//  - Upstream requesters are reset alongside the arbiter.
//  Assertions (sim only)
//  - grant_o onehot0.
//  - In e_busy, header of the locked requester is stable between beats.
// CONFIGURATION
//  BP_ME_STREAM_ARB_PERF_EN defined
//  - Adds output port msg_cnt_o [num_req_p*cnt_width_p].
//  - Counter i increments on each accepted last beat from requester i; saturates at all-ones.
//  - Counters reset to 0 asynchronously.
//  BP_ME_STREAM_ARB_PERF_EN undefined
//  - Port msg_cnt_o and all counter logic are absent; behaviour is otherwise identical.
// TESTING
//  1. Requesters 0 and 1 both valid with 4-beat messages, ready=1 ->
//     beats 0-3 from req0, then beats 0-3 from req1; no interleave; grant_o=01 then 10.
//  2. num_req_p=3, all three continuously send 1-beat messages, ready=1 ->
//     grant order 0,1,2,0,1,2; rr_ptr_r wraps 2->0.
//  3. req0 mid-message drops valid for 3 cycles while req1 is valid ->
//     out_msg_v_o=0 for 3 cycles, req1 ready stays 0, then req0 resumes.
//  4. out_msg_ready_and_i=0 for 5 cycles with req1 valid ->
//     out_msg_v_o=1 held, header and data stable, in_msg_ready_and_o=0, no state change.
//  5. reset_n_i pulsed low after beat 2 of a 4-beat req1 message ->
//     outputs 0 immediately; after release, req0 and req1 valid -> req0 granted (rr_ptr_r=0).
//  6. PERF_EN: 3 messages from req0 and 2 from req1 -> msg_cnt_o = {16'd2,16'd3};
//     with cnt_width_p=2 and 5 messages from req0, counter saturates at 3.

Source files
------------

// File: rtl/bp_me_stream_arbiter_if.sv
// Stream bundle between the requesters, the arbiter and the downstream consumer.
// slave = arbiter side, master = environment (requesters + consumer).
interface bp_me_stream_arbiter_if #(
    parameter int num_req_p      = 2,
    parameter int header_width_p = 128,
    parameter int data_width_p   = 64
);
    logic [num_req_p*header_width_p-1:0] in_msg_header_i;
    logic [num_req_p*data_width_p-1:0]   in_msg_data_i;
    logic [num_req_p-1:0]                in_msg_v_i;
    logic [num_req_p-1:0]                in_msg_last_i;
    logic [num_req_p-1:0]                in_msg_ready_and_o;
    logic [header_width_p-1:0]           out_msg_header_o;
    logic [data_width_p-1:0]             out_msg_data_o;
    logic                                out_msg_v_o;
    logic                                out_msg_last_o;
    logic                                out_msg_ready_and_i;
    logic [num_req_p-1:0]                grant_o;

    modport slave (
        input  in_msg_header_i, in_msg_data_i, in_msg_v_i, in_msg_last_i,
        input  out_msg_ready_and_i,
        output in_msg_ready_and_o, out_msg_header_o, out_msg_data_o,
        output out_msg_v_o, out_msg_last_o, grant_o
    );

    modport master (
        output in_msg_header_i, in_msg_data_i, in_msg_v_i, in_msg_last_i,
        output out_msg_ready_and_i,
        input  in_msg_ready_and_o, out_msg_header_o, out_msg_data_o,
        input  out_msg_v_o, out_msg_last_o, grant_o
    );
endinterface

// File: rtl/bp_me_stream_arbiter.sv
// Round-robin BedRock stream arbiter; grant locks for a whole message.
// Optional BP_ME_STREAM_ARB_PERF_EN adds saturating per-requester message counters.
module bp_me_stream_arbiter #(
    parameter int num_req_p      = 2,
    parameter int header_width_p = 128,
    parameter int data_width_p   = 64,
    parameter int cnt_width_p    = 16
) (
    input  logic                    clk_i,
    input  logic                    reset_n_i,
    bp_me_stream_arbiter_if.slave   bus
`ifdef BP_ME_STREAM_ARB_PERF_EN
    ,
    output logic [num_req_p*cnt_width_p-1:0] msg_cnt_o
`endif
);

    localparam int ptr_w_lp = $clog2(num_req_p);
    localparam logic [0:0] e_ready = 1'b0;
    localparam logic [0:0] e_busy  = 1'b1;
    localparam logic [ptr_w_lp-1:0] last_id_lp = ptr_w_lp'(num_req_p - 1);
    localparam logic [ptr_w_lp:0]   num_lp     = (ptr_w_lp + 1)'(num_req_p);

    if (num_req_p < 2 || cnt_width_p < 1) begin : g_param_check
        $error("bp_me_stream_arbiter: num_req_p must be >= 2, cnt_width_p >= 1");
    end

    logic [0:0]                state_r;
    logic [ptr_w_lp-1:0]       lock_id_r;
    logic [ptr_w_lp-1:0]       rr_ptr_r;
    logic [ptr_w_lp-1:0]       rr_sel;
    logic [ptr_w_lp-1:0]       sel;
    logic [ptr_w_lp-1:0]       sel_next;
    logic                      active;
    logic                      accept;
    logic [num_req_p-1:0]      grant;
    logic [header_width_p-1:0] out_hdr;
    logic [data_width_p-1:0]   out_data;
    logic                      out_v;
    logic                      out_last;

    // first valid requester at or after rr_ptr_r, wrapping modulo num_req_p
    always_comb begin
        logic [ptr_w_lp:0] idx;
        logic              found;
        idx    = '0;
        found  = 1'b0;
        rr_sel = rr_ptr_r;
        for (int k = 0; k < num_req_p; k++) begin
            idx = {1'b0, rr_ptr_r} + (ptr_w_lp + 1)'(k);
            if (idx >= num_lp) idx = idx - num_lp;
            if (!found && bus.in_msg_v_i[idx[ptr_w_lp-1:0]]) begin
                found  = 1'b1;
                rr_sel = idx[ptr_w_lp-1:0];
            end
        end
    end

    // zero-latency mux of the selected requester onto the output
    always_comb begin
        sel      = (state_r == e_busy) ? lock_id_r : rr_sel;
        sel_next = (sel == last_id_lp) ? '0 : sel + ptr_w_lp'(1);
        active   = reset_n_i & ((state_r == e_busy) | (|bus.in_msg_v_i));
        grant    = '0;
        out_hdr  = '0;
        out_data = '0;
        for (int i = 0; i < num_req_p; i++) begin
            if (active && sel == ptr_w_lp'(i)) begin
                grant[i] = 1'b1;
                out_hdr  = bus.in_msg_header_i[i*header_width_p +: header_width_p];
                out_data = bus.in_msg_data_i[i*data_width_p +: data_width_p];
            end
        end
        out_v    = |(grant & bus.in_msg_v_i);
        out_last = |(grant & bus.in_msg_last_i);
        accept   = out_v & bus.out_msg_ready_and_i;
    end

    assign bus.grant_o            = grant;
    assign bus.out_msg_header_o   = out_hdr;
    assign bus.out_msg_data_o     = out_data;
    assign bus.out_msg_v_o        = out_v;
    assign bus.out_msg_last_o     = out_last;
    assign bus.in_msg_ready_and_o = {num_req_p{bus.out_msg_ready_and_i}} & grant;

    // lock on a non-last first beat, release and advance the pointer on last
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_r   <= e_ready;
            lock_id_r <= '0;
            rr_ptr_r  <= '0;
        end else if (accept) begin
            if (state_r == e_ready) begin
                if (out_last) begin
                    rr_ptr_r <= sel_next;
                end else begin
                    state_r   <= e_busy;
                    lock_id_r <= sel;
                end
            end else if (out_last) begin
                state_r  <= e_ready;
                rr_ptr_r <= sel_next;
            end
        end
    end

`ifdef BP_ME_STREAM_ARB_PERF_EN
    for (genvar i = 0; i < num_req_p; i++) begin : g_cnt
        logic [cnt_width_p-1:0] cnt_r;

        // count accepted last beats of requester i, saturating at all-ones
        always_ff @(posedge clk_i or negedge reset_n_i) begin
            if (!reset_n_i) begin
                cnt_r <= '0;
            end else if (accept && out_last && grant[i] && !(&cnt_r)) begin
                cnt_r <= cnt_r + cnt_width_p'(1);
            end
        end

        assign msg_cnt_o[i*cnt_width_p +: cnt_width_p] = cnt_r;
    end
`endif

`ifndef SYNTHESIS
    logic [header_width_p-1:0] hdr_hold_r;

    // header of the first beat of the message currently holding the lock
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            hdr_hold_r <= '0;
        end else if (accept && state_r == e_ready && !out_last) begin
            hdr_hold_r <= out_hdr;
        end
    end

    a_grant_onehot: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        $onehot0(grant));

    a_hdr_stable: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        (state_r == e_busy && out_v) |-> (out_hdr == hdr_hold_r));
`endif

endmodule

// File: tb/tb_bp_me_stream_arbiter.sv
// Directed bench for bp_me_stream_arbiter with a beat scoreboard.
// Three requesters so that non-power-of-2 pointer wrap is exercised.
module tb_bp_me_stream_arbiter;

    localparam int NREQ = 3;
    localparam int HW   = 32;
    localparam int DW   = 16;
    localparam int CW   = 16;

    typedef struct packed {
        logic [HW-1:0] hdr;
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    typedef struct packed {
        logic [NREQ-1:0] gnt;
        beat_t           b;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int exp_cnt [NREQ];

    exp_t      sb [$];
    beat_t     src_mem [NREQ][64];
    logic [5:0] wr_p [NREQ] = '{default: '0};
    logic [5:0] rd_p [NREQ] = '{default: '0};
    logic [NREQ-1:0] hold = '0;
    logic flush = 1'b1;

    bp_me_stream_arbiter_if #(
        .num_req_p(NREQ), .header_width_p(HW), .data_width_p(DW)
    ) bus ();

`ifdef BP_ME_STREAM_ARB_PERF_EN
    logic [NREQ*CW-1:0] msg_cnt;
`endif

    bp_me_stream_arbiter #(
        .num_req_p(NREQ), .header_width_p(HW),
        .data_width_p(DW), .cnt_width_p(CW)
    ) dut (
        .clk_i(clk),
        .reset_n_i(rst_n),
        .bus(bus)
`ifdef BP_ME_STREAM_ARB_PERF_EN
        , .msg_cnt_o(msg_cnt)
`endif
    );

    // requester models: present the head beat of each source queue
    always_comb begin
        bus.in_msg_header_i = '0;
        bus.in_msg_data_i   = '0;
        bus.in_msg_v_i      = '0;
        bus.in_msg_last_i   = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (rd_p[i] != wr_p[i] && !hold[i]) begin
                bus.in_msg_v_i[i]               = 1'b1;
                bus.in_msg_header_i[i*HW +: HW] = src_mem[i][rd_p[i]].hdr;
                bus.in_msg_data_i[i*DW +: DW]   = src_mem[i][rd_p[i]].data;
                bus.in_msg_last_i[i]            = src_mem[i][rd_p[i]].last;
            end
        end
    end

    // requester models: advance on handshake, drop everything on flush
    always @(posedge clk) begin
        for (int i = 0; i < NREQ; i++) begin
            if (flush) rd_p[i] <= wr_p[i];
            else if (bus.in_msg_v_i[i] && bus.in_msg_ready_and_o[i])
                rd_p[i] <= rd_p[i] + 6'd1;
        end
    end

    // scoreboard: every accepted output beat must match the next expected one
    always @(negedge clk) begin
        if (rst_n && bus.out_msg_v_o && bus.out_msg_ready_and_i) begin
            checks++;
            assert (sb.size() != 0) else begin
                errors++;
                $error("FAIL sb_extra: beat hdr=%h data=%h, required none",
                       bus.out_msg_header_o, bus.out_msg_data_o);
            end
            if (sb.size() != 0) begin
                exp_t e;
                exp_t o;
                e = sb.pop_front();
                o = {bus.grant_o, bus.out_msg_header_o,
                     bus.out_msg_data_o, bus.out_msg_last_o};
                checks++;
                assert (o === e) else begin
                    errors++;
                    $error("FAIL sb_beat: got gnt=%b hdr=%h data=%h last=%b, required gnt=%b hdr=%h data=%h last=%b",
                           o.gnt, o.b.hdr, o.b.data, o.b.last,
                           e.gnt, e.b.hdr, e.b.data, e.b.last);
                end
                for (int i = 0; i < NREQ; i++)
                    if (e.gnt[i] && e.b.last) exp_cnt[i]++;
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h, required %h", tag, obs, exp);
        end
    endtask

    task automatic push_msg(input int r, input int n,
                            input logic [HW-1:0] h, input logic [DW-1:0] d0);
        for (int j = 0; j < n; j++) begin
            beat_t b;
            exp_t  e;
            b.hdr  = h;
            b.data = d0 + DW'(j);
            b.last = (j == n - 1);
            src_mem[r][wr_p[r]] = b;
            wr_p[r] = wr_p[r] + 6'd1;
            e.gnt = NREQ'(1) << r;
            e.b   = b;
            sb.push_back(e);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drain(input string tag, input int budget);
        int n;
        n = 0;
        while (sb.size() != 0 && n < budget) begin
            step();
            n++;
        end
        chk(tag, 64'(sb.size()), 64'd0);
    endtask

    initial begin
        for (int i = 0; i < NREQ; i++) exp_cnt[i] = 0;
        bus.out_msg_ready_and_i = 1'b1;
        repeat (3) step();
        chk("reset_grant", 64'(bus.grant_o), 64'd0);
        chk("reset_v", 64'(bus.out_msg_v_o), 64'd0);
        chk("reset_ready", 64'(bus.in_msg_ready_and_o), 64'd0);
        rst_n = 1'b1;
        flush = 1'b0;
        step();

        // two 4-beat messages competing: req0 fully, then req1
        push_msg(0, 4, 32'h1000_0000, 16'h0100);
        push_msg(1, 4, 32'h1111_0000, 16'h0110);
        #1;
        chk("t1_first_grant", 64'(bus.grant_o), 64'b001);
        wait_drain("t1_drain", 20);

        // single-beat rotation starting at req2, wraps 2->0
        push_msg(2, 1, 32'h2000_0000, 16'h0200);
        push_msg(0, 1, 32'h2000_0001, 16'h0201);
        push_msg(1, 1, 32'h2000_0002, 16'h0202);
        push_msg(2, 1, 32'h2000_0003, 16'h0203);
        push_msg(0, 1, 32'h2000_0004, 16'h0204);
        push_msg(1, 1, 32'h2000_0005, 16'h0205);
        push_msg(2, 1, 32'h2000_0006, 16'h0206);
        push_msg(0, 1, 32'h2000_0007, 16'h0207);
        #1;
        chk("t2_first_grant", 64'(bus.grant_o), 64'b100);
        wait_drain("t2_drain", 20);

        // req0 bubbles mid-message while req1 waits
        hold = 3'b010;
        push_msg(0, 4, 32'h3000_0000, 16'h0300);
        push_msg(1, 2, 32'h3111_0000, 16'h0310);
        step();
        step();
        hold = 3'b001;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("t3_bubble_v", 64'(bus.out_msg_v_o), 64'd0);
            chk("t3_req1_ready", 64'(bus.in_msg_ready_and_o[1]), 64'd0);
            chk("t3_grant_locked", 64'(bus.grant_o), 64'b001);
        end
        step();
        hold = 3'b000;
        wait_drain("t3_drain", 20);

        // downstream stall: beat held stable, no upstream ready
        bus.out_msg_ready_and_i = 1'b0;
        push_msg(1, 2, 32'h4111_0000, 16'h0410);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("t4_v", 64'(bus.out_msg_v_o), 64'd1);
            chk("t4_hdr", 64'(bus.out_msg_header_o), 64'h4111_0000);
            chk("t4_data", 64'(bus.out_msg_data_o), 64'h0410);
            chk("t4_ready", 64'(bus.in_msg_ready_and_o), 64'd0);
        end
        step();
        bus.out_msg_ready_and_i = 1'b1;
        wait_drain("t4_drain", 20);

        // reset in the middle of a req1 message
        push_msg(1, 4, 32'h5111_0000, 16'h0510);
        step();
        step();
        rst_n = 1'b0;
        #1;
        chk("t5_rst_v", 64'(bus.out_msg_v_o), 64'd0);
        chk("t5_rst_grant", 64'(bus.grant_o), 64'd0);
        chk("t5_rst_hdr", 64'(bus.out_msg_header_o), 64'd0);
        chk("t5_rst_data", 64'(bus.out_msg_data_o), 64'd0);
        chk("t5_rst_last", 64'(bus.out_msg_last_o), 64'd0);
        chk("t5_rst_ready", 64'(bus.in_msg_ready_and_o), 64'd0);
        flush = 1'b1;
        sb.delete();
        for (int i = 0; i < NREQ; i++) exp_cnt[i] = 0;
        step();
        step();
        rst_n = 1'b1;
        flush = 1'b0;
        push_msg(0, 1, 32'h5000_0001, 16'h0501);
        push_msg(1, 1, 32'h5111_0001, 16'h0511);
        #1;
        chk("t5_post_grant", 64'(bus.grant_o), 64'b001);
        wait_drain("t5_drain", 20);

        // message counting: 3 more from req0, 2 more from req1
        push_msg(0, 1, 32'h6000_0000, 16'h0600);
        push_msg(1, 2, 32'h6111_0000, 16'h0610);
        push_msg(0, 3, 32'h6000_0001, 16'h0620);
        push_msg(1, 1, 32'h6111_0001, 16'h0630);
        push_msg(0, 1, 32'h6000_0002, 16'h0640);
        wait_drain("t6_drain", 30);
        chk("t6_model_cnt0", 64'(exp_cnt[0]), 64'd4);
        chk("t6_model_cnt1", 64'(exp_cnt[1]), 64'd3);
`ifdef BP_ME_STREAM_ARB_PERF_EN
        for (int i = 0; i < NREQ; i++)
            chk("t6_msg_cnt", 64'(msg_cnt[i*CW +: CW]), 64'(exp_cnt[i]));
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, required completion");
        $fatal(1, "timeout");
    end

endmodule
